ddr_tx_serializer: RTL and testbench

//  Gearbox between a word-wide valid/ready stream and per-lane DDR output primitives.

---
 rtl/ddr_tx_serializer.sv | 175 +++++++++++++++++
 tb/tb_ddr_tx_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_tx_serializer.sv
// ---------------------------------------------------------------------------
// ddr_tx_serializer
//   Gearbox from a word-wide valid/ready stream to per-lane DDR output cells.
//   Each word is cut into BEATS slices of 2*LANES bits. Each clock the low
//   half of the current slice goes to d1_o (rising edge) and the high half
//   goes to d2_o (falling edge). Frames are marked with en1_o/en2_o. After
//   the beat that carries s_last_i, the block holds at least IFG_CYCLES idle
//   clocks before it accepts the next frame.
//
// Ports
//   clk_i      in   1       rising-edge clock
//   arstn_i    in   1       asynchronous active-low reset
//   s_data_i   in   DATA_W  input word, sampled only on a transfer
//   s_valid_i  in   1       s_data_i/s_last_i valid
//   s_last_i   in   1       word closes the frame
//   s_ready_o  out  1       word accepted this cycle if s_valid_i is high
//   d1_o       out  LANES   rising-edge bits
//   d2_o       out  LANES   falling-edge bits
//   en1_o      out  1       data enable, rising edge
//   en2_o      out  1       data enable, falling edge (same as en1_o)
//   busy_o     out  1       sending a frame or holding the inter-frame gap
// ---------------------------------------------------------------------------

// One DDR lane: registers the rising- and falling-edge bits for the next
// clock. The bits are forced to 0 whenever the enable is low.
module ddr_tx_lane (
   input  logic clk_i,
   input  logic arstn_i,
   input  logic en_n,
   input  logic r_n,
   input  logic f_n,
   output logic d1_o,
   output logic d2_o
);
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         d1_o <= 1'b0;
         d2_o <= 1'b0;
      end else begin
         d1_o <= en_n & r_n;
         d2_o <= en_n & f_n;
      end
   end
endmodule

module ddr_tx_serializer #(
   parameter int DATA_W     = 8,
   parameter int LANES      = 4,
   parameter int IFG_CYCLES = 12
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_valid_i,
   input  logic              s_last_i,
   output logic              s_ready_o,
   output logic [LANES-1:0]  d1_o,
   output logic [LANES-1:0]  d2_o,
   output logic              en1_o,
   output logic              en2_o,
   output logic              busy_o
);
   localparam int SLICE_W = 2 * LANES;
   localparam int BEATS   = DATA_W / SLICE_W;
   localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int GW      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   // The state registers describe what is on the output pins right now.
   // For example, SEND with beat_q == k means beat k of word_q is being driven.
   state_t            state_q, state_n;
   logic [DATA_W-1:0] word_q, word_n;
   logic              last_q, last_n;
   logic [BW-1:0]     beat_q, beat_n;
   logic [GW-1:0]     gap_q, gap_n;
   logic              fin, rdy, xfer;
   logic [SLICE_W-1:0] slice_n;

   assign fin = (beat_q == BEAT_LAST);

   always_comb begin
      rdy = 1'b0;
      case (state_q)
         IDLE:    rdy = 1'b1;
         SEND:    rdy = fin && (!last_q || (IFG_CYCLES == 0));
         default: rdy = 1'b0;
      endcase
   end

   // The reset term keeps ready low while reset is held, even though the
   // state register already reads IDLE.
   assign s_ready_o = arstn_i & rdy;
   assign xfer      = s_valid_i & s_ready_o;

   always_comb begin
      state_n = state_q;
      word_n  = word_q;
      last_n  = last_q;
      beat_n  = beat_q;
      gap_n   = gap_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               state_n = SEND;
               word_n  = s_data_i;
               last_n  = s_last_i;
               beat_n  = '0;
            end
         end
         SEND: begin
            if (!fin) begin
               beat_n = beat_q + BW'(1);
            end else if (xfer) begin
               // Back-to-back word. Its beat 0 follows with no bubble.
               word_n = s_data_i;
               last_n = s_last_i;
               beat_n = '0;
            end else if (last_q && (IFG_CYCLES > 0)) begin
               state_n = GAP;
               gap_n   = '0;
            end else begin
               // End of frame with no gap, or underrun. An underrun leaves
               // the frame broken and is not flagged.
               state_n = IDLE;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_n = IDLE;
            else                   gap_n   = gap_q + GW'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= IDLE;
         word_q  <= '0;
         last_q  <= 1'b0;
         beat_q  <= '0;
         gap_q   <= '0;
         en1_o   <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_n;
         word_q  <= word_n;
         last_q  <= last_n;
         beat_q  <= beat_n;
         gap_q   <= gap_n;
         en1_o   <= (state_n == SEND);
         busy_o  <= (state_n != IDLE);
      end
   end

   assign en2_o = en1_o;

   // The output registers are loaded from the next-state word and beat, so
   // the pins stay in step with state_q.
   assign slice_n = word_n[int'(beat_n) * SLICE_W +: SLICE_W];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      ddr_tx_lane u_lane (
         .clk_i   (clk_i),
         .arstn_i (arstn_i),
         .en_n    (state_n == SEND),
         .r_n     (slice_n[l]),
         .f_n     (slice_n[LANES + l]),
         .d1_o    (d1_o[l]),
         .d2_o    (d2_o[l])
      );
   end
endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Two instances share one clock and one reset.
//   Unit a: LANES=4, DATA_W=8, IFG_CYCLES=12 (1 beat per word).
//   Unit b: LANES=2, DATA_W=8, IFG_CYCLES=0  (2 beats per word).
// Drivers push the expected beats, tagged with the cycle they must appear
// on, into a per-unit queue. They also record the last cycle of any gap
// window. A negedge monitor derives en/ready/busy from that schedule and
// compares them with the DUT.
module tb_ddr_tx_serializer;
   logic clk = 1'b0;
   logic arstn;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] a_data, b_data;
   logic       a_valid, a_last, a_ready, a_en1, a_en2, a_busy;
   logic       b_valid, b_last, b_ready, b_en1, b_en2, b_busy;
   logic [3:0] a_d1, a_d2;
   logic [1:0] b_d1, b_d2;

   ddr_tx_serializer #(.DATA_W(8), .LANES(4), .IFG_CYCLES(12)) dut_a (
      .clk_i(clk), .arstn_i(arstn), .s_data_i(a_data), .s_valid_i(a_valid),
      .s_last_i(a_last), .s_ready_o(a_ready), .d1_o(a_d1), .d2_o(a_d2),
      .en1_o(a_en1), .en2_o(a_en2), .busy_o(a_busy));

   ddr_tx_serializer #(.DATA_W(8), .LANES(2), .IFG_CYCLES(0)) dut_b (
      .clk_i(clk), .arstn_i(arstn), .s_data_i(b_data), .s_valid_i(b_valid),
      .s_last_i(b_last), .s_ready_o(b_ready), .d1_o(b_d1), .d2_o(b_d2),
      .en1_o(b_en1), .en2_o(b_en2), .busy_o(b_busy));

   typedef struct { int cyc; int d1; int d2; } beat_t;
   beat_t qa[$], qb[$];
   int gap_a = -1, gap_b = -1;
   int n_chk = 0, n_pass = 0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference: word w accepted in cycle c shows beat k in cycle c+1+k.
   // The rising-edge half of slice k is bits [2Lk +: L]; the falling-edge
   // half is the next L bits. A last word opens a gap window of ifg cycles
   // after its final beat.
   function automatic void push_word(int u, int w, bit last, int c);
      int L   = u ? 2 : 4;
      int B   = 8 / (2 * L);
      int ifg = u ? 0 : 12;
      int m   = (1 << L) - 1;
      for (int k = 0; k < B; k++) begin
         beat_t e;
         e.cyc = c + 1 + k;
         e.d1  = (w >> (2 * L * k)) & m;
         e.d2  = (w >> (2 * L * k + L)) & m;
         if (u == 0) qa.push_back(e); else qb.push_back(e);
      end
      if (last && ifg > 0) begin
         if (u == 0) gap_a = c + B + ifg; else gap_b = c + B + ifg;
      end
   endfunction

   task automatic mon(int u);
      string p    = u ? "b" : "a";
      int    d1   = u ? int'(b_d1) : int'(a_d1);
      int    d2   = u ? int'(b_d2) : int'(a_d2);
      int    en1  = u ? int'(b_en1) : int'(a_en1);
      int    en2  = u ? int'(b_en2) : int'(a_en2);
      int    busy = u ? int'(b_busy) : int'(a_busy);
      int    rdy  = u ? int'(b_ready) : int'(a_ready);
      int    gap  = u ? gap_b : gap_a;
      bit    has = 0, later = 0;
      beat_t e;
      if (!arstn) begin
         chk({p, "_rst_outs"}, (d1 << 8) | (d2 << 4) | (en1 << 2) | (en2 << 1) | busy, 0);
         chk({p, "_rst_ready"}, rdy, 0);
         return;
      end
      if (u == 0) begin
         if (qa.size() > 0 && qa[0].cyc == cyc) begin has = 1; e = qa.pop_front(); end
         later = qa.size() > 0;
      end else begin
         if (qb.size() > 0 && qb[0].cyc == cyc) begin has = 1; e = qb.pop_front(); end
         later = qb.size() > 0;
      end
      if (has) begin
         chk({p, "_d1"}, d1, e.d1);
         chk({p, "_d2"}, d2, e.d2);
      end else begin
         chk({p, "_d_idle"}, (d1 << 4) | d2, 0);
      end
      chk({p, "_en1"}, en1, int'(has));
      chk({p, "_en2"}, en2, int'(has));
      chk({p, "_ready"}, rdy, int'(!later && cyc > gap));
      chk({p, "_busy"}, busy, int'(has || cyc <= gap));
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // Offers one word and holds it until it is accepted. The word is pushed
   // to the model in the cycle the transfer happens. The task returns at
   // posedge+1 with valid low, so a following call keeps valid high.
   task automatic put(int u, int w, bit last);
      if (u == 0) begin a_data = 8'(w); a_last = last; a_valid = 1'b1; end
      else        begin b_data = 8'(w); b_last = last; b_valid = 1'b1; end
      for (int t = 0; ; t++) begin
         @(negedge clk); #1;
         if ((u == 0) ? a_ready : b_ready) begin
            push_word(u, w, last, cyc);
            break;
         end
         if (t == 300) begin
            chk(u ? "b_ready_timeout" : "a_ready_timeout", int'(u ? b_ready : a_ready), 1);
            break;
         end
      end
      @(posedge clk); #1;
      if (u == 0) begin a_valid = 1'b0; a_data = 8'($urandom); a_last = 1'($urandom); end
      else        begin b_valid = 1'b0; b_data = 8'($urandom); b_last = 1'($urandom); end
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic random_frames(int u, int nfr);
      for (int f = 0; f < nfr; f++) begin
         int len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) begin
            put(u, $urandom_range(0, 255), i == len - 1);
            // Occasional hole between words; mid-frame this is an underrun.
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
         if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 4));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      // Reset with valid driven on both units.
      arstn = 1'b0;
      a_valid = 1'b1; a_data = 8'hFF; a_last = 1'b1;
      b_valid = 1'b1; b_data = 8'hFF; b_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a_valid = 1'b0; b_valid = 1'b0;
      #2 arstn = 1'b1;
      idle(2);

      fork
         begin
            put(0, 8'hA5, 1);                // d1=5, d2=A, then a 12-cycle gap
            put(0, 8'h11, 0);                // three words with valid held high
            put(0, 8'h22, 0);
            put(0, 8'h33, 1);
            put(0, 8'h11, 0);                // underrun
            idle(3);
            random_frames(0, 10);
         end
         begin
            put(1, 8'hC6, 1);                // beat0 10/01, beat1 00/11
            put(1, 8'h3C, 1);                // back-to-back frames with no gap
            put(1, 8'h11, 0);                // underrun after one word
            idle(3);
            random_frames(1, 20);
         end
      join
      idle(20);
      chk("a_drain", qa.size(), 0);
      chk("b_drain", qb.size(), 0);

      // Reset in the middle of unit b's beat 0.
      put(1, 8'hC6, 0);
      #2 arstn = 1'b0;
      #1;
      chk("b_async_rst_outs", (int'(b_d1) << 4) | (int'(b_d2) << 2) | (int'(b_en1) << 1) | int'(b_busy), 0);
      chk("b_async_rst_ready", int'(b_ready), 0);
      qa.delete(); qb.delete(); gap_a = -1; gap_b = -1;
      idle(2);
      #2 arstn = 1'b1;
      idle(3);
      put(1, 8'h5A, 1);
      put(0, 8'h96, 1);
      idle(20);
      chk("a_drain_end", qa.size(), 0);
      chk("b_drain_end", qb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
